// File: rtl/mips_mem_port_arbiter.sv
// mips_mem_port_arbiter: shares the single data-memory port between the MEM stage and the debug port.
// Define MIPS_MEM_ARB_FWD_EN to serve pipe reads that hit the last-write entry without a memory access.
module mips_mem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pipeReq,
    input  logic              pipeWe,
    input  logic [ADDR_W-1:0] pipeAddr,
    input  logic [DATA_W-1:0] pipeWData,
    output logic              pipeAck,
    output logic [DATA_W-1:0] pipeRData,
    output logic              pipeErr,
    output logic              pipeStall,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWData,
    output logic              dbgAck,
    output logic [DATA_W-1:0] dbgRData,
    output logic              dbgErr,
    output logic              memReq,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWData,
    input  logic              memAck,
    input  logic [DATA_W-1:0] memRData
);
    localparam int STARVE_W = $clog2(STARVE_MAX + 1);
    localparam int CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam int TO_LAST  = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

    typedef enum logic [1:0] {IDLE, BUSY_PIPE, BUSY_DBG} state_t;

    state_t              state;
    logic [STARVE_W-1:0] starve;
    logic [CNT_W-1:0]    busy_cnt;
    logic                pipe_elig;
    logic                dbg_elig;
    logic                starved;
    logic                grant_dbg;
    logic                grant_pipe;
    logic                timeout_hit;
    logic                fwd_hit;
    logic                fwd_valid;
    logic [ADDR_W-1:0]   fwd_addr;
    logic [DATA_W-1:0]   fwd_data;

    // A requester whose ack is showing still holds its finished request, so it is not eligible.
    assign pipe_elig   = pipeReq & ~pipeAck;
    assign dbg_elig    = dbgReq & ~dbgAck;
    assign starved     = (starve == STARVE_W'(STARVE_MAX));
    assign grant_dbg   = (state == IDLE) & dbg_elig & (starved | ~pipe_elig);
    assign grant_pipe  = (state == IDLE) & pipe_elig & ~grant_dbg;
    assign timeout_hit = (TIMEOUT != 0) && (busy_cnt == CNT_W'(TO_LAST));
    assign fwd_hit     = fwd_valid & ~pipeWe & (pipeAddr == fwd_addr);
    assign pipeStall   = pipeReq & ~pipeAck;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            starve <= '0;
        end else if (!dbgReq || grant_dbg) begin
            starve <= '0;
        end else if (dbg_elig && (state != BUSY_DBG) && !starved) begin
            starve <= starve + STARVE_W'(1);
        end
    end

`ifdef MIPS_MEM_ARB_FWD_EN
    // Only writes that memory acknowledged refresh the entry; aborted writes leave it alone.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_data  <= '0;
        end else if ((state != IDLE) && memAck && memWe) begin
            fwd_valid <= 1'b1;
            fwd_addr  <= memAddr;
            fwd_data  <= memWData;
        end
    end
`else
    assign fwd_valid = 1'b0;
    assign fwd_addr  = '0;
    assign fwd_data  = '0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy_cnt  <= '0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memAddr   <= '0;
            memWData  <= '0;
            pipeAck   <= 1'b0;
            pipeErr   <= 1'b0;
            pipeRData <= '0;
            dbgAck    <= 1'b0;
            dbgErr    <= 1'b0;
            dbgRData  <= '0;
        end else begin
            pipeAck   <= 1'b0;
            pipeErr   <= 1'b0;
            pipeRData <= '0;
            dbgAck    <= 1'b0;
            dbgErr    <= 1'b0;
            dbgRData  <= '0;
            case (state)
                IDLE: begin
                    busy_cnt <= '0;
                    if (grant_dbg) begin
                        memReq   <= 1'b1;
                        memWe    <= dbgWe;
                        memAddr  <= dbgAddr;
                        memWData <= dbgWData;
                        state    <= BUSY_DBG;
                    end else if (grant_pipe && fwd_hit) begin
                        pipeAck   <= 1'b1;
                        pipeRData <= fwd_data;
                    end else if (grant_pipe) begin
                        memReq   <= 1'b1;
                        memWe    <= pipeWe;
                        memAddr  <= pipeAddr;
                        memWData <= pipeWData;
                        state    <= BUSY_PIPE;
                    end
                end
                BUSY_PIPE, BUSY_DBG: begin
                    // memAck outranks a simultaneous timeout, so err is simply the absence of memAck.
                    if (memAck || timeout_hit) begin
                        memReq <= 1'b0;
                        state  <= IDLE;
                        if (state == BUSY_PIPE) begin
                            pipeAck   <= 1'b1;
                            pipeErr   <= ~memAck;
                            pipeRData <= (memAck && !memWe) ? memRData : '0;
                        end else begin
                            dbgAck   <= 1'b1;
                            dbgErr   <= ~memAck;
                            dbgRData <= (memAck && !memWe) ? memRData : '0;
                        end
                    end else begin
                        busy_cnt <= busy_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
